// File: rtl/game_logic_renderer.sv
// Rhythm-slash game core: one target block flies toward the player, hand points retire it
// as a hit, otherwise it retires as a miss; per-pixel scene colour is produced one cycle late.
module game_logic_renderer #(
    parameter int TICK_CYCLES = 650000,
    parameter int Z_START     = 1024,
    parameter int Z_STEP      = 64,
    parameter int HIT_Z       = 256,
    parameter int HIT_HALF    = 48
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic [10:0] x_in,
    input  logic [9:0]  y_in,
    input  logic [11:0] hand_x_left_bottom,
    input  logic [11:0] hand_y_left_bottom,
    input  logic [11:0] hand_x_left_top,
    input  logic [11:0] hand_y_left_top,
    input  logic [11:0] hand_x_right_bottom,
    input  logic [11:0] hand_y_right_bottom,
    input  logic [11:0] hand_x_right_top,
    input  logic [11:0] hand_y_right_top,
    input  logic [13:0] hand_z_left_bottom,
    input  logic [13:0] hand_z_left_top,
    input  logic [13:0] hand_z_right_bottom,
    input  logic [13:0] hand_z_right_top,
    input  logic [11:0] head_x,
    input  logic [11:0] head_y,
    input  logic [13:0] head_z,
    output logic [4:0]  r_out,
    output logic [5:0]  g_out,
    output logic [4:0]  b_out,
    output logic [15:0] curr_time_out,
    output logic [1:0]  curr_block_index_out,
    output logic [11:0] block_x_out,
    output logic [11:0] block_y_out,
    output logic [13:0] block_z_out,
    output logic        block_missed_out,
    output logic [7:0]  score_out
);
    localparam int PW = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
    localparam logic [PW-1:0] TICK_LAST  = PW'(TICK_CYCLES - 1);
    localparam logic [13:0]   Z_START_V  = 14'(Z_START);
    localparam logic [13:0]   Z_STEP_V   = 14'(Z_STEP);
    localparam logic [13:0]   HIT_Z_V    = 14'(HIT_Z);
    localparam logic [12:0]   HIT_HALF_V = 13'(HIT_HALF);
    localparam logic [12:0]   DOT_HALF   = 13'd4;

    function automatic logic [11:0] table_x(input logic [1:0] idx);
        case (idx)
            2'd0:    return 12'd312;
            2'd1:    return 12'd512;
            2'd2:    return 12'd712;
            default: return 12'd512;
        endcase
    endfunction

    function automatic logic [11:0] table_y(input logic [1:0] idx);
        return (idx == 2'd3) ? 12'd250 : 12'd384;
    endfunction

    function automatic logic [12:0] abs13(input logic signed [12:0] v);
        return v[12] ? 13'(-v) : 13'(v);
    endfunction

    // Coordinates are zero-extended into 13-bit signed so screen-edge differences never wrap.
    function automatic logic near(input logic [11:0] ax, input logic [11:0] ay,
                                  input logic [11:0] bx, input logic [11:0] by,
                                  input logic [12:0] lim);
        logic signed [12:0] dx;
        logic signed [12:0] dy;
        dx = $signed({1'b0, ax}) - $signed({1'b0, bx});
        dy = $signed({1'b0, ay}) - $signed({1'b0, by});
        return (abs13(dx) <= lim) && (abs13(dy) <= lim);
    endfunction

    logic [PW-1:0] prescaler;
    logic [11:0]   hand_x [4];
    logic [11:0]   hand_y [4];
    logic [11:0]   px;
    logic [11:0]   py;
    logic [12:0]   block_half;
    logic          tick;
    logic          hit;
    logic          hand_hit;
    logic          hand_pix;
    logic          head_pix;
    logic          block_pix;
    logic [1:0]    next_index;
    logic [4:0]    pix_r;
    logic [5:0]    pix_g;
    logic [4:0]    pix_b;
    logic          unused_depth;

    assign unused_depth = ^{hand_z_left_bottom, hand_z_left_top, hand_z_right_bottom,
                            hand_z_right_top, head_z};

    assign hand_x[0] = hand_x_left_bottom;
    assign hand_y[0] = hand_y_left_bottom;
    assign hand_x[1] = hand_x_left_top;
    assign hand_y[1] = hand_y_left_top;
    assign hand_x[2] = hand_x_right_bottom;
    assign hand_y[2] = hand_y_right_bottom;
    assign hand_x[3] = hand_x_right_top;
    assign hand_y[3] = hand_y_right_top;

    assign px         = {1'b0, x_in};
    assign py         = {2'b0, y_in};
    assign block_half = 13'((Z_START_V - block_z_out) >> 4) + 13'd8;
    assign tick       = (prescaler == TICK_LAST);
    assign next_index = curr_block_index_out + 2'd1;

    always_comb begin
        hand_hit = 1'b0;
        hand_pix = 1'b0;
        for (int i = 0; i < 4; i++) begin
            hand_hit = hand_hit | near(hand_x[i], hand_y[i], block_x_out, block_y_out, HIT_HALF_V);
            hand_pix = hand_pix | near(hand_x[i], hand_y[i], px, py, DOT_HALF);
        end
        head_pix  = near(head_x, head_y, px, py, DOT_HALF);
        block_pix = near(block_x_out, block_y_out, px, py, block_half);
        hit       = (block_z_out <= HIT_Z_V) && hand_hit;
    end

    // Colour priority: hand dots over head dot over block over black background.
    always_comb begin
        pix_r = 5'd0;
        pix_g = 6'd0;
        pix_b = 5'd0;
        if (hand_pix) begin
            pix_r = 5'd31;
            pix_g = 6'd63;
            pix_b = 5'd31;
        end else if (head_pix) begin
            pix_r = 5'd31;
            pix_g = 6'd63;
        end else if (block_pix) begin
            if (curr_block_index_out[0]) pix_b = 5'd31;
            else                         pix_r = 5'd31;
        end
    end

    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            prescaler            <= '0;
            curr_time_out        <= '0;
            curr_block_index_out <= 2'd0;
            block_x_out          <= table_x(2'd0);
            block_y_out          <= table_y(2'd0);
            block_z_out          <= Z_START_V;
            block_missed_out     <= 1'b0;
            score_out            <= '0;
            r_out                <= '0;
            g_out                <= '0;
            b_out                <= '0;
        end else begin
            prescaler <= tick ? '0 : prescaler + 1'b1;
            if (tick) curr_time_out <= curr_time_out + 16'd1;

            // A hit retires immediately and takes precedence over a coincident tick.
            if (hit) begin
                curr_block_index_out <= next_index;
                block_x_out          <= table_x(next_index);
                block_y_out          <= table_y(next_index);
                block_z_out          <= Z_START_V;
                block_missed_out     <= 1'b0;
                score_out            <= score_out + 8'd1;
            end else if (tick) begin
                if (block_z_out == 14'd0) begin
                    curr_block_index_out <= next_index;
                    block_x_out          <= table_x(next_index);
                    block_y_out          <= table_y(next_index);
                    block_z_out          <= Z_START_V;
                    block_missed_out     <= 1'b1;
                end else begin
                    block_z_out <= block_z_out - Z_STEP_V;
                end
            end

            r_out <= pix_r;
            g_out <= pix_g;
            b_out <= pix_b;
        end
    end
endmodule

// File: tb/tb_game_logic_renderer.sv
// Randomized bench for game_logic_renderer: a behavioural game model predicts every cycle's
// outputs into a queue that a negedge monitor drains and compares.
module tb_game_logic_renderer;
    localparam int TICK     = 10;
    localparam int Z_START  = 1024;
    localparam int Z_STEP   = 64;
    localparam int HIT_Z    = 256;
    localparam int HIT_HALF = 48;

    logic        clk = 1'b0;
    logic        rst;
    logic [10:0] x_in;
    logic [9:0]  y_in;
    logic [11:0] hxlb, hylb, hxlt, hylt, hxrb, hyrb, hxrt, hyrt;
    logic [11:0] head_x, head_y;
    logic [13:0] hz = 14'd0;
    logic [4:0]  r_out;
    logic [5:0]  g_out;
    logic [4:0]  b_out;
    logic [15:0] curr_time;
    logic [1:0]  idx;
    logic [11:0] bx, by;
    logic [13:0] bz;
    logic        missed;
    logic [7:0]  score;

    always #5 clk = ~clk;

    game_logic_renderer #(.TICK_CYCLES(TICK), .Z_START(Z_START), .Z_STEP(Z_STEP),
                          .HIT_Z(HIT_Z), .HIT_HALF(HIT_HALF)) dut (
        .clk_in(clk), .rst_in(rst), .x_in(x_in), .y_in(y_in),
        .hand_x_left_bottom(hxlb), .hand_y_left_bottom(hylb),
        .hand_x_left_top(hxlt), .hand_y_left_top(hylt),
        .hand_x_right_bottom(hxrb), .hand_y_right_bottom(hyrb),
        .hand_x_right_top(hxrt), .hand_y_right_top(hyrt),
        .hand_z_left_bottom(hz), .hand_z_left_top(hz),
        .hand_z_right_bottom(hz), .hand_z_right_top(hz),
        .head_x(head_x), .head_y(head_y), .head_z(hz),
        .r_out(r_out), .g_out(g_out), .b_out(b_out),
        .curr_time_out(curr_time), .curr_block_index_out(idx),
        .block_x_out(bx), .block_y_out(by), .block_z_out(bz),
        .block_missed_out(missed), .score_out(score)
    );

    typedef struct packed {
        logic [31:0] cyc;
        logic [15:0] tm;
        logic [1:0]  idx;
        logic [11:0] bx;
        logic [11:0] by;
        logic [13:0] bz;
        logic        missed;
        logic [7:0]  score;
        logic [15:0] rgb;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;

    int tbl_x[4] = '{312, 512, 712, 512};
    int tbl_y[4] = '{384, 384, 384, 250};
    int m_presc, m_time, m_idx, m_z, m_score;
    bit m_missed;

    function automatic int iabs(input int v);
        return (v < 0) ? -v : v;
    endfunction

    function automatic bit near(input int ax, input int ay, input int bx_, input int by_, input int lim);
        return (iabs(ax - bx_) <= lim) && (iabs(ay - by_) <= lim);
    endfunction

    function automatic int clip(input int v, input int hi);
        return (v < 0) ? 0 : ((v > hi) ? hi : v);
    endfunction

    task automatic model_reset();
        m_presc = 0; m_time = 0; m_idx = 0; m_z = Z_START; m_score = 0; m_missed = 0;
    endtask

    // Predict the outputs visible after the coming rising edge from the inputs held now.
    task automatic model_edge();
        exp_t e;
        int hx[4], hy[4];
        bit hit, hand_p, tick;
        int half;
        logic [15:0] rgb;
        hx[0] = hxlb; hy[0] = hylb; hx[1] = hxlt; hy[1] = hylt;
        hx[2] = hxrb; hy[2] = hyrb; hx[3] = hxrt; hy[3] = hyrt;
        rgb = 16'h0000;
        if (!rst) begin
            model_reset();
        end else begin
            hand_p = 0;
            hit = 0;
            for (int i = 0; i < 4; i++) begin
                if (near(hx[i], hy[i], x_in, y_in, 4)) hand_p = 1;
                if (m_z <= HIT_Z && near(hx[i], hy[i], tbl_x[m_idx], tbl_y[m_idx], HIT_HALF)) hit = 1;
            end
            half = ((Z_START - m_z) / 16) + 8;
            if (hand_p)                                   rgb = 16'hFFFF;
            else if (near(head_x, head_y, x_in, y_in, 4)) rgb = 16'hFFE0;
            else if (near(tbl_x[m_idx], tbl_y[m_idx], x_in, y_in, half))
                rgb = (m_idx % 2 == 0) ? 16'hF800 : 16'h001F;
            tick = (m_presc == TICK - 1);
            m_presc = tick ? 0 : m_presc + 1;
            if (tick) m_time = (m_time + 1) % 65536;
            if (hit) begin
                m_idx = (m_idx + 1) % 4; m_z = Z_START; m_score = (m_score + 1) % 256; m_missed = 0;
            end else if (tick) begin
                if (m_z == 0) begin
                    m_idx = (m_idx + 1) % 4; m_z = Z_START; m_missed = 1;
                end else begin
                    m_z = m_z - Z_STEP;
                end
            end
        end
        e.cyc = 32'(cyc + 1);
        e.tm = 16'(m_time); e.idx = 2'(m_idx);
        e.bx = 12'(tbl_x[m_idx]); e.by = 12'(tbl_y[m_idx]); e.bz = 14'(m_z);
        e.missed = m_missed; e.score = 8'(m_score); e.rgb = rgb;
        exp_q.push_back(e);
    endtask

    task automatic step();
        model_edge();
        @(posedge clk);
        cyc++;
        @(negedge clk);
    endtask

    task automatic chk(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, actual, expected);
        end
    endtask

    task automatic set_hands(input int x, input int y);
        hxlb = 12'(x); hylb = 12'(y); hxlt = 12'(x); hylt = 12'(y);
        hxrb = 12'(x); hyrb = 12'(y); hxrt = 12'(x); hyrt = 12'(y);
    endtask

    task automatic rand_pixel();
        int sel;
        sel = $urandom_range(0, 3);
        case (sel)
            0: begin x_in = 11'(clip(tbl_x[m_idx] + $urandom_range(0, 160) - 80, 2047));
                     y_in = 10'(clip(tbl_y[m_idx] + $urandom_range(0, 160) - 80, 1023)); end
            1: begin x_in = 11'(clip(int'(hxlb) + $urandom_range(0, 12) - 6, 2047));
                     y_in = 10'(clip(int'(hylb) + $urandom_range(0, 12) - 6, 1023)); end
            2: begin x_in = 11'(clip(int'(head_x) + $urandom_range(0, 12) - 6, 2047));
                     y_in = 10'(clip(int'(head_y) + $urandom_range(0, 12) - 6, 1023)); end
            default: begin x_in = 11'($urandom_range(0, 1023)); y_in = 10'($urandom_range(0, 767)); end
        endcase
    endtask

    task automatic rand_point(output logic [11:0] x, output logic [11:0] y);
        if ($urandom_range(0, 3) == 0) begin
            x = 12'(clip(tbl_x[m_idx] + $urandom_range(0, 120) - 60, 4095));
            y = 12'(clip(tbl_y[m_idx] + $urandom_range(0, 120) - 60, 4095));
        end else begin
            x = 12'($urandom_range(0, 1100));
            y = 12'($urandom_range(0, 800));
        end
    endtask

    always @(negedge clk) begin
        exp_t e, got;
        while (exp_q.size() > 0 && exp_q[0].cyc == 32'(cyc)) begin
            e = exp_q.pop_front();
            got = '{cyc: e.cyc, tm: curr_time, idx: idx, bx: bx, by: by, bz: bz,
                    missed: missed, score: score, rgb: {r_out, g_out, b_out}};
            checks++;
            if (got !== e) begin
                errors++;
                $display("FAIL scoreboard cyc=%0d got t=%0d i=%0d x=%0d y=%0d z=%0d m=%0d s=%0d rgb=%h expected t=%0d i=%0d x=%0d y=%0d z=%0d m=%0d s=%0d rgb=%h",
                         cyc, got.tm, got.idx, got.bx, got.by, got.bz, got.missed, got.score, got.rgb,
                         e.tm, e.idx, e.bx, e.by, e.bz, e.missed, e.score, e.rgb);
            end
        end
    end

    initial begin
        rst = 1'b0;
        set_hands(0, 0);
        head_x = 12'd0; head_y = 12'd0;
        x_in = 11'd0; y_in = 10'd0;
        model_reset();
        @(negedge clk);
        step();
        step();
        chk("reset_time", curr_time, 0);
        chk("reset_index", idx, 0);
        chk("reset_block_x", bx, 312);
        chk("reset_block_y", by, 384);
        chk("reset_block_z", bz, 1024);
        chk("reset_missed", missed, 0);
        chk("reset_score", score, 0);
        chk("reset_rgb", {r_out, g_out, b_out}, 0);

        rst = 1'b1;
        set_hands(2000, 2000);
        head_x = 12'd900; head_y = 12'd700;
        x_in = 11'd312; y_in = 10'd384; step();
        chk("block_centre_red", {r_out, g_out, b_out}, 16'hF800);
        x_in = 11'd320; step();
        chk("block_edge_red", {r_out, g_out, b_out}, 16'hF800);
        x_in = 11'd321; step();
        chk("block_outside_black", {r_out, g_out, b_out}, 0);
        for (int i = 0; i < 47; i++) begin rand_pixel(); step(); end
        chk("time_50", curr_time, 5);
        chk("z_50", bz, 704);
        for (int i = 0; i < 50; i++) begin rand_pixel(); step(); end
        chk("time_100", curr_time, 10);
        chk("z_100", bz, 384);
        for (int i = 0; i < 70; i++) begin rand_pixel(); step(); end
        chk("miss_index", idx, 1);
        chk("miss_block_x", bx, 512);
        chk("miss_block_y", by, 384);
        chk("miss_block_z", bz, 1024);
        chk("miss_flag", missed, 1);
        chk("miss_score", score, 0);

        rst = 1'b0; step();
        chk("midgame_reset_index", idx, 0);
        rst = 1'b1;
        for (int i = 0; i < 120; i++) begin rand_pixel(); step(); end
        chk("hittable_z", bz, 256);
        hxlt = 12'd312; hylt = 12'd384; step();
        chk("hit_index", idx, 1);
        chk("hit_missed", missed, 0);
        chk("hit_score", score, 1);
        chk("hit_new_z", bz, 1024);

        set_hands(2000, 2000);
        hxlb = 12'd100; hylb = 12'd100;
        x_in = 11'd104; y_in = 10'd96; step();
        chk("hand_dot_white", {r_out, g_out, b_out}, 16'hFFFF);
        x_in = 11'd105; y_in = 10'd100; step();
        chk("hand_dot_outside", {r_out, g_out, b_out}, 0);
        head_x = 12'd600; head_y = 12'd600;
        x_in = 11'd596; y_in = 10'd604; step();
        chk("head_dot_yellow", {r_out, g_out, b_out}, 16'hFFE0);

        for (int i = 0; i < 3000; i++) begin
            rst = ($urandom_range(0, 399) != 0);
            if (i % 8 == 0) begin
                rand_point(hxlb, hylb); rand_point(hxlt, hylt);
                rand_point(hxrb, hyrb); rand_point(hxrt, hyrt);
                head_x = 12'($urandom_range(0, 1023)); head_y = 12'($urandom_range(0, 767));
            end
            rand_pixel();
            step();
        end
        @(negedge clk);
        chk("queue_drained", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
